ro_freq_counter: RTL and testbench



---
 rtl/tc_pkg.sv | 19 +
 rtl/tc_sync_edge.sv | 32 +++
 rtl/ro_freq_counter.sv | 177 +++++++++++++++++
 tb/tb_ro_freq_counter.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/tc_pkg.sv
// Shared types and constants for the technology-characterization blocks.
package tc_pkg;

    // Measurement sequencer states.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARM   = 2'd1,
        ST_COUNT = 2'd2,
        ST_LATCH = 2'd3
    } tc_state_e;

    // Readout byte select that returns the status byte instead of count data.
    localparam logic [1:0] BSEL_STATUS = 2'd3;

    // Default widths of the edge counter and the gate-length input.
    localparam int DEF_CNT_W  = 24;
    localparam int DEF_GATE_W = 16;

endpackage

// File: rtl/tc_sync_edge.sv
// Multi-flop synchronizer for an asynchronous input followed by a rising-edge
// detector. Produces a one-cycle pulse in the clk domain for every rising
// transition of the synchronized signal.
module tc_sync_edge #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic async_i,
    output logic edge_o
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   last_q;

    // Shift the async input through the synchronizer and keep the previous
    // synchronized value for edge detection.
    // NOTE: non-blocking assignments let every flop sample the pre-edge value,
    // so the chain really is SYNC_STAGES flops deep.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= '0;
            last_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], async_i};
            last_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign edge_o = sync_q[SYNC_STAGES-1] & ~last_q;

endmodule

// File: rtl/ro_freq_counter.sv
// Ring-oscillator frequency counter: counts synchronized RO rising edges over
// a programmable window of clk cycles, latches the saturating result and
// presents it byte-wise for the pad outputs.
// Optional build macro RO_PRESCALE_EN inserts a 2^PRESCALE_LOG2 ripple
// divider, clocked by the RO itself, ahead of the synchronizer.
module ro_freq_counter
    import tc_pkg::*;
#(
    parameter int CNT_W         = DEF_CNT_W,
    parameter int GATE_W        = DEF_GATE_W,
    parameter int SYNC_STAGES   = 2,
    parameter int PRESCALE_LOG2 = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [GATE_W-1:0] gate_cycles,
    input  logic              ro_in,
    input  logic [1:0]        byte_sel,
    output logic              busy,
    output logic              done,
    output logic              overflow,
    output logic [CNT_W-1:0]  count,
    output logic [7:0]        data_out
);

    localparam int               NBYTES  = CNT_W / 8;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    if ((CNT_W % 8) != 0 || CNT_W > 24 || CNT_W < 8) begin : g_bad_cnt_w
        $error("CNT_W must be a multiple of 8 between 8 and 24");
    end
    if (SYNC_STAGES < 2) begin : g_bad_sync
        $error("SYNC_STAGES must be at least 2");
    end
    if (PRESCALE_LOG2 < 1) begin : g_bad_prescale
        $error("PRESCALE_LOG2 must be at least 1");
    end

    // ------------------------------------------------------------------
    // RO source selection
    // ------------------------------------------------------------------
    logic ro_src;

`ifdef RO_PRESCALE_EN
    // div_clk[i] clocks divider stage i; each stage toggles on its input's
    // rising edge and passes on its inverted output, giving a ripple count.
    logic [PRESCALE_LOG2:0] div_clk;
    assign div_clk[0] = ro_in;

    for (genvar i = 0; i < PRESCALE_LOG2; i++) begin : g_div
        logic toggle_q;
        // Divide-by-two stage clocked by the previous stage.
        always_ff @(posedge div_clk[i] or posedge rst) begin
            if (rst) toggle_q <= 1'b0;
            else     toggle_q <= ~toggle_q;
        end
        assign div_clk[i+1] = ~toggle_q;
    end

    assign ro_src = ~div_clk[PRESCALE_LOG2];
`else
    assign ro_src = ro_in;
`endif

    logic edge_pulse;

    tc_sync_edge #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync_edge (
        .clk     (clk),
        .rst     (rst),
        .async_i (ro_src),
        .edge_o  (edge_pulse)
    );

    // ------------------------------------------------------------------
    // Measurement sequencer
    // ------------------------------------------------------------------
    tc_state_e         state_q,    state_d;
    logic [GATE_W-1:0] gate_q,     gate_d;
    logic [GATE_W-1:0] timer_q,    timer_d;
    logic [CNT_W-1:0]  edge_cnt_q, edge_cnt_d;
    logic              sat_q,      sat_d;
    logic [CNT_W-1:0]  count_q,    count_d;
    logic              ovf_q,      ovf_d;

    // Next-state logic: sequencing, edge counting with saturation, result latch.
    // NOTE: every signal gets its hold value first so no path leaves one
    // unassigned, which is what would otherwise infer a latch.
    always_comb begin
        state_d    = state_q;
        gate_d     = gate_q;
        timer_d    = timer_q;
        edge_cnt_d = edge_cnt_q;
        sat_d      = sat_q;
        count_d    = count_q;
        ovf_d      = ovf_q;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d    = ST_ARM;
                    gate_d     = gate_cycles;
                    timer_d    = GATE_W'(SYNC_STAGES - 1);
                    edge_cnt_d = '0;
                    sat_d      = 1'b0;
                end
            end
            ST_ARM: begin
                // Let stale synchronizer contents drain before counting.
                if (timer_q == '0) begin
                    if (gate_q == '0) begin
                        state_d = ST_LATCH;
                    end else begin
                        state_d = ST_COUNT;
                        timer_d = gate_q - GATE_W'(1);
                    end
                end else begin
                    timer_d = timer_q - GATE_W'(1);
                end
            end
            ST_COUNT: begin
                if (edge_pulse) begin
                    if (edge_cnt_q == CNT_MAX) sat_d = 1'b1;
                    else                       edge_cnt_d = edge_cnt_q + CNT_W'(1);
                end
                if (timer_q == '0) state_d = ST_LATCH;
                else               timer_d = timer_q - GATE_W'(1);
            end
            ST_LATCH: state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase

        // Capture the final count on entry to LATCH so it is valid with done.
        if (state_d == ST_LATCH) begin
            count_d = edge_cnt_d;
            ovf_d   = sat_d;
        end
    end

    // State and datapath registers; reset clears the latched result too.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            gate_q     <= '0;
            timer_q    <= '0;
            edge_cnt_q <= '0;
            sat_q      <= 1'b0;
            count_q    <= '0;
            ovf_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            gate_q     <= gate_d;
            timer_q    <= timer_d;
            edge_cnt_q <= edge_cnt_d;
            sat_q      <= sat_d;
            count_q    <= count_d;
            ovf_q      <= ovf_d;
        end
    end

    assign busy     = (state_q == ST_ARM) || (state_q == ST_COUNT);
    assign done     = (state_q == ST_LATCH);
    assign count    = count_q;
    assign overflow = ovf_q;

    // Byte readout mux: count bytes LSB first, then the status byte.
    always_comb begin
        data_out = 8'h00;
        for (int i = 0; i < NBYTES; i++) begin
            if (byte_sel == 2'(i)) data_out = count_q[8*i +: 8];
        end
        if (byte_sel == BSEL_STATUS && CNT_W < 32) data_out = {7'b0, ovf_q};
    end

endmodule

// File: tb/tb_ro_freq_counter.sv
// Self-checking bench for ro_freq_counter. Two instances (24-bit and 8-bit
// counters) share all inputs so saturation is reachable in a short run.
// Expected counts come from the period of the generated RO: a periodic
// signal of period P clk cycles has exactly g/P rising edges in any window of
// g consecutive cycles when P divides g.
module tb_ro_freq_counter;

    localparam int GW = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [GW-1:0] gate_cycles;
    logic          ro_in;
    logic [1:0]    byte_sel;

    logic          busy_a, done_a, ovf_a;
    logic [23:0]   count_a;
    logic [7:0]    data_a;
    logic          busy_b, done_b, ovf_b;
    logic [7:0]    count_b;
    logic [7:0]    data_b;

    int total = 0;
    int bad   = 0;
    int ro_period = 0;
    int ro_ph = 0;

    ro_freq_counter #(.CNT_W(24), .GATE_W(GW), .SYNC_STAGES(2)) dut_a (
        .clk(clk), .rst(rst), .start(start), .gate_cycles(gate_cycles),
        .ro_in(ro_in), .byte_sel(byte_sel), .busy(busy_a), .done(done_a),
        .overflow(ovf_a), .count(count_a), .data_out(data_a)
    );

    ro_freq_counter #(.CNT_W(8), .GATE_W(GW), .SYNC_STAGES(2)) dut_b (
        .clk(clk), .rst(rst), .start(start), .gate_cycles(gate_cycles),
        .ro_in(ro_in), .byte_sel(byte_sel), .busy(busy_b), .done(done_b),
        .overflow(ovf_b), .count(count_b), .data_out(data_b)
    );

    always #5 clk = ~clk;

    // RO model: period ro_period clk cycles, edges 3 time units after posedge.
    initial begin
        ro_in = 1'b0;
        forever begin
            @(posedge clk);
            #3;
            if (ro_period < 2) begin
                ro_in = 1'b0;
            end else begin
                ro_ph = (ro_ph + 1) % ro_period;
                ro_in = (ro_ph < ro_period / 2);
            end
        end
    end

    function automatic int exp_count(input int g, input int p, input int w);
        int edges, maxv;
        edges = g / p;
        maxv  = (1 << w) - 1;
        return (edges > maxv) ? maxv : edges;
    endfunction

    function automatic logic exp_ovf(input int g, input int p, input int w);
        return (g / p) > ((1 << w) - 1);
    endfunction

    task automatic set_ro(input int p);
        ro_period = p;
        repeat (2 * p + 6) @(negedge clk);
    endtask

    // Issue a start and observe the run for g+10 cycles (bounded).
    task automatic run(input int g, input int extra_at, input int rst_at,
                       output int done_at, output int n_done, output int busy_cyc,
                       output logic [7:0] hold_b);
        gate_cycles = g[GW-1:0];
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        hold_b   = count_b;
        done_at  = -1;
        n_done   = 0;
        busy_cyc = 0;
        for (int n = 1; n <= g + 10; n++) begin
            if (n > 1) @(negedge clk);
            start = 1'b0;
            if (n == rst_at) return;
            if (done_a) begin
                n_done++;
                if (done_at < 0) done_at = n;
            end
            if (busy_a) busy_cyc++;
            if (n == extra_at) begin
                start = 1'b1;
                gate_cycles = GW'(5);
            end
        end
        start = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; gate_cycles = '0; byte_sel = 2'd3;
        repeat (3) @(negedge clk);
        total++; if (busy_a !== 1'b0) begin bad++; $display("FAIL reset busy got %0b want 0", busy_a); end
        total++; if (done_a !== 1'b0) begin bad++; $display("FAIL reset done got %0b want 0", done_a); end
        total++; if (ovf_a !== 1'b0) begin bad++; $display("FAIL reset overflow got %0b want 0", ovf_a); end
        total++; if (count_a !== 24'd0) begin bad++; $display("FAIL reset count got %0d want 0", count_a); end
        total++; if (data_b !== 8'd0) begin bad++; $display("FAIL reset data_out got %0d want 0", data_b); end
        rst = 1'b0;
        byte_sel = 2'd0;
        @(negedge clk);
    endtask

    task automatic test_direct();
        int done_at, n_done, busy_cyc;
        logic [7:0] hold;
        logic [7:0] exp_bytes [4];
        set_ro(10);
        run(1000, 0, 0, done_at, n_done, busy_cyc, hold);
        total++; if (done_at !== 1003) begin bad++; $display("FAIL direct latency got %0d want 1003", done_at); end
        total++; if (n_done !== 1) begin bad++; $display("FAIL direct done pulses got %0d want 1", n_done); end
        total++; if (count_a !== 24'(exp_count(1000, 10, 24))) begin bad++; $display("FAIL direct count got %0d want %0d", count_a, exp_count(1000, 10, 24)); end
        total++; if (ovf_a !== 1'b0) begin bad++; $display("FAIL direct overflow got %0b want 0", ovf_a); end
        total++; if (count_b !== 8'd100) begin bad++; $display("FAIL direct count8 got %0d want 100", count_b); end
        exp_bytes[0] = 8'h64; exp_bytes[1] = 8'h00; exp_bytes[2] = 8'h00; exp_bytes[3] = 8'h00;
        for (int i = 0; i < 4; i++) begin
            byte_sel = 2'(i);
            #1;
            total++; if (data_a !== exp_bytes[i]) begin bad++; $display("FAIL direct byte%0d got %0h want %0h", i, data_a, exp_bytes[i]); end
        end
        byte_sel = 2'd0;
    endtask

    task automatic test_saturation();
        int done_at, n_done, busy_cyc;
        logic [7:0] hold;
        set_ro(2);
        run(600, 0, 0, done_at, n_done, busy_cyc, hold);
        total++; if (count_b !== 8'd255) begin bad++; $display("FAIL sat count8 got %0d want 255", count_b); end
        total++; if (ovf_b !== 1'b1) begin bad++; $display("FAIL sat overflow8 got %0b want 1", ovf_b); end
        total++; if (count_a !== 24'd300) begin bad++; $display("FAIL sat count24 got %0d want 300", count_a); end
        total++; if (ovf_a !== 1'b0) begin bad++; $display("FAIL sat overflow24 got %0b want 0", ovf_a); end
        byte_sel = 2'd3;
        #1;
        total++; if (data_b !== 8'h01) begin bad++; $display("FAIL sat status8 got %0h want 01", data_b); end
        total++; if (data_a !== 8'h00) begin bad++; $display("FAIL sat status24 got %0h want 00", data_a); end
        byte_sel = 2'd0;
        run(100, 0, 0, done_at, n_done, busy_cyc, hold);
        total++; if (hold !== 8'd255) begin bad++; $display("FAIL sat hold after start got %0d want 255", hold); end
        total++; if (count_b !== 8'd50) begin bad++; $display("FAIL sat rerun count8 got %0d want 50", count_b); end
        total++; if (ovf_b !== 1'b0) begin bad++; $display("FAIL sat rerun overflow8 got %0b want 0", ovf_b); end
        total++; if (done_at !== 103) begin bad++; $display("FAIL sat rerun latency got %0d want 103", done_at); end
    endtask

    task automatic test_zero_gate();
        int done_at, n_done, busy_cyc;
        logic [7:0] hold;
        set_ro(4);
        run(0, 0, 0, done_at, n_done, busy_cyc, hold);
        total++; if (done_at !== 3) begin bad++; $display("FAIL zero latency got %0d want 3", done_at); end
        total++; if (busy_cyc !== 2) begin bad++; $display("FAIL zero busy cycles got %0d want 2", busy_cyc); end
        total++; if (count_a !== 24'd0) begin bad++; $display("FAIL zero count got %0d want 0", count_a); end
        total++; if (n_done !== 1) begin bad++; $display("FAIL zero done pulses got %0d want 1", n_done); end
    endtask

    task automatic test_start_while_busy();
        int done_at, n_done, busy_cyc;
        logic [7:0] hold;
        set_ro(10);
        run(1000, 50, 0, done_at, n_done, busy_cyc, hold);
        total++; if (n_done !== 1) begin bad++; $display("FAIL busy-start done pulses got %0d want 1", n_done); end
        total++; if (done_at !== 1003) begin bad++; $display("FAIL busy-start latency got %0d want 1003", done_at); end
        total++; if (count_a !== 24'd100) begin bad++; $display("FAIL busy-start count got %0d want 100", count_a); end
    endtask

    task automatic test_reset_mid();
        int done_at, n_done, busy_cyc;
        logic [7:0] hold;
        run(1000, 0, 503, done_at, n_done, busy_cyc, hold);
        rst = 1'b1;
        #1;
        total++; if (busy_a !== 1'b0) begin bad++; $display("FAIL midrst busy got %0b want 0", busy_a); end
        total++; if (done_a !== 1'b0) begin bad++; $display("FAIL midrst done got %0b want 0", done_a); end
        total++; if (count_a !== 24'd0) begin bad++; $display("FAIL midrst count got %0d want 0", count_a); end
        total++; if (ovf_a !== 1'b0) begin bad++; $display("FAIL midrst overflow got %0b want 0", ovf_a); end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        run(200, 0, 0, done_at, n_done, busy_cyc, hold);
        total++; if (done_at !== 203) begin bad++; $display("FAIL postrst latency got %0d want 203", done_at); end
        total++; if (count_a !== 24'd20) begin bad++; $display("FAIL postrst count got %0d want 20", count_a); end
    endtask

    task automatic test_random();
        int done_at, n_done, busy_cyc;
        logic [7:0] hold;
        int p, k, g, e24, e8;
        logic o8;
        logic [7:0] exp_a, exp_b;
        for (int it = 0; it < 6; it++) begin
            p = int'($urandom_range(2, 12));
            k = int'($urandom_range(1, 300));
            g = p * k;
            e24 = exp_count(g, p, 24);
            e8  = exp_count(g, p, 8);
            o8  = exp_ovf(g, p, 8);
            set_ro(p);
            run(g, 0, 0, done_at, n_done, busy_cyc, hold);
            total++; if (done_at !== g + 3) begin bad++; $display("FAIL rand%0d latency got %0d want %0d", it, done_at, g + 3); end
            total++; if (count_a !== 24'(e24)) begin bad++; $display("FAIL rand%0d count24 P=%0d g=%0d got %0d want %0d", it, p, g, count_a, e24); end
            total++; if (count_b !== 8'(e8)) begin bad++; $display("FAIL rand%0d count8 got %0d want %0d", it, count_b, e8); end
            total++; if (ovf_b !== o8) begin bad++; $display("FAIL rand%0d overflow8 got %0b want %0b", it, ovf_b, o8); end
            for (int i = 0; i < 4; i++) begin
                byte_sel = 2'(i);
                #1;
                exp_a = (i < 3) ? 8'((e24 >> (8 * i)) & 255) : 8'h00;
                exp_b = (i == 0) ? 8'(e8) : ((i == 3) ? {7'b0, o8} : 8'h00);
                total++; if (data_a !== exp_a) begin bad++; $display("FAIL rand%0d byte%0d a got %0h want %0h", it, i, data_a, exp_a); end
                total++; if (data_b !== exp_b) begin bad++; $display("FAIL rand%0d byte%0d b got %0h want %0h", it, i, data_b, exp_b); end
            end
            byte_sel = 2'd0;
        end
    endtask

    initial begin
        test_reset();
        test_direct();
        test_saturation();
        test_zero_gate();
        test_start_while_busy();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
